ov5640_data_cap: RTL and testbench
==================================

Name: ov5640_data_cap

Overview:
- Upstream capture stage for the RGB565-to-YCbCr converter.
- Samples the OV5640 8-bit DVP bus: vsync, href, and a byte per clock.
- Assembles byte pairs into 16-bit RGB565 pixels.
- Discards the first FRAME_SKIP frames after reset, while the sensor settles.
- Presents each pixel as a one-cycle pre_wr_en strobe plus ov5640_data, which the converter consumes directly.

Parameters:
- FRAME_SKIP, 10, number of complete frames discarded after reset before output is enabled (0 = output from first frame).
- H_PIXELS, 640, expected pixels per line (used only with CAP_FRAME_CHECK_EN).
- V_LINES, 480, expected lines per frame (used only with CAP_FRAME_CHECK_EN).

Ports:
- sys_clk  in  1  capture clock (camera pclk domain); all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- cam_vsync  in  1  frame sync; rising edge marks frame start.
- cam_href  in  1  line valid; bytes are valid while high.
- cam_data  in  8  DVP byte.
- pre_wr_en  out  1  one-cycle strobe; ov5640_data is valid in this cycle.
- ov5640_data  out  16  assembled RGB565 pixel, {first byte, second byte}.
- frame_start  out  1  one-cycle pulse on each vsync rising edge while in ACTIVE.
- cap_err  out  1  sticky geometry error (CAP_FRAME_CHECK_EN only, else 0).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; frame counter 0; byte toggle 0; input registers 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once (stage r1). vsync_d holds the previous r1 vsync value.
- Edge detect: vs_rise = r1_vsync & ~vsync_d.
- FSM:
  - IDLE -> SKIP on vs_rise. If FRAME_SKIP==0, IDLE -> ACTIVE directly.
  - SKIP: each vs_rise increments the frame counter. When the counter reaches FRAME_SKIP, go to ACTIVE on that same vs_rise.
  - ACTIVE: stays there until reset.
  - Frame counter width is clog2(FRAME_SKIP+1). It saturates and never wraps.
- Byte assembly (all states):
  - While r1_href=1: toggle flips every cycle. Toggle=0 latches the high byte; toggle=1 completes the pixel.
  - When r1_href=0: toggle clears to 0. A dangling high byte from an odd-length line is discarded silently.
- Output:
  - On pixel completion in ACTIVE, the next edge registers ov5640_data={hi,lo} and pulses pre_wr_en=1.
  - Latency: the low byte at the pins before edge E0 gives pre_wr_en high during the cycle after E2 (2 cycles).
  - pre_wr_en is never high on two consecutive cycles.
  - ov5640_data holds its last value between strobes.
- frame_start: registered pulse one cycle after vs_rise, ACTIVE state only.
- vsync high together with href high: the pixel is still captured. The vsync edge does not clear the toggle; only href low does.
- Reset mid-frame: everything returns to IDLE, and skipping restarts from 0 at the next vs_rise.

Optional Feature:
- Macro: CAP_FRAME_CHECK_EN.
- Defined:
  - Pixel counter per line; it resets when href falls.
  - Line counter counts href falling edges; it resets on vs_rise.
  - In ACTIVE, cap_err sets if a line ends with pixel count != H_PIXELS.
  - In ACTIVE, cap_err sets if a vs_rise arrives with line count != V_LINES. The first ACTIVE vs_rise is excluded.
  - cap_err is sticky until sys_rst.
  - Counters are clog2(H_PIXELS+1) and clog2(V_LINES+1) bits wide and saturate.
- Undefined: no counters are generated; cap_err is tied 0.

Decomposition:
- Shared package ov5640_pkg:
  - state typedef {IDLE, SKIP, ACTIVE};
  - RGB565 width constant (16);
  - default H_PIXELS/V_LINES constants.
- One natural sub-module: ov5640_edge_det, a registered rising/falling edge detector. It is instantiated for vsync and for href.

Test Plan (FRAME_SKIP=2, H_PIXELS=4, V_LINES=2 unless noted):
- Frame skip:
  - Stimulus: 3 frames of 2 lines x 8 bytes.
  - Required: zero pre_wr_en during frames 1-2; 8 strobes in frame 3; frame_start only at the vsync rise that opens frame 3.
- Byte order:
  - Stimulus: in ACTIVE, bytes 0xF8,0x1F.
  - Required: ov5640_data=0xF81F with pre_wr_en exactly 2 cycles after the 0x1F byte is sampled; single-cycle strobe.
- Odd line:
  - Stimulus: href high for 7 bytes.
  - Required: 3 strobes; next line starts with a fresh high byte (bytes 0x12,0x34 give 0x1234).
  - Required with CAP_FRAME_CHECK_EN: cap_err=1 and stays 1.
- Reset mid-line:
  - Stimulus: assert sys_rst in ACTIVE mid-line.
  - Required: outputs 0 immediately; after release, 2 frames skipped again before output resumes.
- FRAME_SKIP=0:
  - Stimulus: first frame.
  - Required: strobes output from the first frame after the first vs_rise.
- Correct geometry:
  - Stimulus: 4 correct frames with CAP_FRAME_CHECK_EN.
  - Required: cap_err stays 0.

Source files
------------

// File: rtl/ov5640_pkg.sv
// Shared state type, bus widths and default geometry for the OV5640 DVP capture path.
package ov5640_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SKIP   = 2'd1,
        ACTIVE = 2'd2
    } cap_state_e;

    localparam int DVP_W        = 8;
    localparam int RGB565_W     = 16;
    localparam int DEF_H_PIXELS = 640;
    localparam int DEF_V_LINES  = 480;

    // Width of a saturating counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ov5640_edge_det.sv
// Registered single-edge detector: FALLING=0 flags 0->1, FALLING=1 flags 1->0 of i_sig.
module ov5640_edge_det #(
    parameter bit FALLING = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_edge
);

    logic r_sig_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sig_d <= 1'b0;
        end else begin
            r_sig_d <= i_sig;
        end
    end

    assign o_edge = FALLING ? (~i_sig & r_sig_d) : (i_sig & ~r_sig_d);

endmodule

// File: rtl/ov5640_data_cap.sv
// OV5640 DVP capture: byte-pair assembly to RGB565, start-up frame skip, pixel strobe output.
// Optional line/frame geometry checking is enabled with the CAP_FRAME_CHECK_EN macro.
module ov5640_data_cap
    import ov5640_pkg::*;
#(
    parameter int FRAME_SKIP = 10,
    parameter int H_PIXELS   = DEF_H_PIXELS,
    parameter int V_LINES    = DEF_V_LINES
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cam_vsync,
    input  logic                cam_href,
    input  logic [DVP_W-1:0]    cam_data,
    output logic                pre_wr_en,
    output logic [RGB565_W-1:0] ov5640_data,
    output logic                frame_start,
    output logic                cap_err
);

    localparam int              FC_W    = cnt_width(FRAME_SKIP);
    localparam logic [FC_W-1:0] FC_MAX  = '1;
    localparam logic [FC_W-1:0] FC_SKIP = FC_W'(FRAME_SKIP);

    logic                r1_vsync;
    logic                r1_href;
    logic [DVP_W-1:0]    r1_data;

    logic                w_vs_rise;
    logic                w_href_fall;
    logic                w_pix_done;
    logic [FC_W-1:0]     w_frame_cnt_inc;

    logic                r_toggle;
    logic [DVP_W-1:0]    r_hi;
    logic [RGB565_W-1:0] r_pix;
    logic                r_pix_vld;

    cap_state_e          r_state;
    logic [FC_W-1:0]     r_frame_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r1_vsync <= 1'b0;
            r1_href  <= 1'b0;
            r1_data  <= '0;
        end else begin
            r1_vsync <= cam_vsync;
            r1_href  <= cam_href;
            r1_data  <= cam_data;
        end
    end

    ov5640_edge_det #(
        .FALLING (1'b0)
    ) u_vsync_edge (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_sig  (r1_vsync),
        .o_edge (w_vs_rise)
    );

    ov5640_edge_det #(
        .FALLING (1'b1)
    ) u_href_edge (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_sig  (r1_href),
        .o_edge (w_href_fall)
    );

    assign w_pix_done      = r1_href & r_toggle;
    assign w_frame_cnt_inc = (r_frame_cnt == FC_MAX) ? r_frame_cnt : r_frame_cnt + 1'b1;

    // Toggle can only be 1 while href is low in the cycle right after href falls, so clearing
    // there drops a dangling high byte and leaves every line starting on a high byte.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_toggle  <= 1'b0;
            r_hi      <= '0;
            r_pix     <= '0;
            r_pix_vld <= 1'b0;
        end else begin
            r_pix_vld <= w_pix_done;
            if (r1_href) begin
                r_toggle <= ~r_toggle;
                if (!r_toggle) begin
                    r_hi <= r1_data;
                end else begin
                    r_pix <= {r_hi, r1_data};
                end
            end else if (w_href_fall) begin
                r_toggle <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_frame_cnt <= '0;
            frame_start <= 1'b0;
            pre_wr_en   <= 1'b0;
            ov5640_data <= '0;
        end else begin
            frame_start <= 1'b0;
            pre_wr_en   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_vs_rise) begin
                        if (FRAME_SKIP == 0) begin
                            r_state     <= ACTIVE;
                            frame_start <= 1'b1;
                        end else begin
                            r_state <= SKIP;
                        end
                    end
                end
                SKIP: begin
                    if (w_vs_rise) begin
                        r_frame_cnt <= w_frame_cnt_inc;
                        if (w_frame_cnt_inc == FC_SKIP) begin
                            r_state     <= ACTIVE;
                            frame_start <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    frame_start <= w_vs_rise;
                    if (r_pix_vld) begin
                        pre_wr_en   <= 1'b1;
                        ov5640_data <= r_pix;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef CAP_FRAME_CHECK_EN
    localparam int              PC_W   = cnt_width(H_PIXELS);
    localparam int              LC_W   = cnt_width(V_LINES);
    localparam logic [PC_W-1:0] PC_MAX = '1;
    localparam logic [LC_W-1:0] LC_MAX = '1;
    localparam logic [PC_W-1:0] PC_EXP = PC_W'(H_PIXELS);
    localparam logic [LC_W-1:0] LC_EXP = LC_W'(V_LINES);

    logic [PC_W-1:0] r_pix_cnt;
    logic [LC_W-1:0] r_line_cnt;
    logic            r_cap_err;
    logic            w_line_bad;
    logic            w_frame_bad;

    assign w_line_bad  = w_href_fall & (r_pix_cnt != PC_EXP);
    // The vs_rise that enters ACTIVE sees r_state != ACTIVE, so it is never judged.
    assign w_frame_bad = w_vs_rise & (r_line_cnt != LC_EXP);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
            r_cap_err  <= 1'b0;
        end else begin
            if (w_href_fall) begin
                r_pix_cnt <= '0;
            end else if (w_pix_done && (r_pix_cnt != PC_MAX)) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end

            if (w_vs_rise) begin
                r_line_cnt <= '0;
            end else if (w_href_fall && (r_line_cnt != LC_MAX)) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end

            if ((r_state == ACTIVE) && (w_line_bad || w_frame_bad)) begin
                r_cap_err <= 1'b1;
            end
        end
    end

    assign cap_err = r_cap_err;
`else
    assign cap_err = 1'b0;
`endif

endmodule

// File: tb/tb_ov5640_data_cap.sv
// Scoreboard bench for ov5640_data_cap: directed DVP frames, queued expectations, negedge monitor.
module tb_ov5640_data_cap;

    localparam int MAIN_SKIP = 2;

    typedef struct packed {
        logic [15:0] data;
        int          due;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        rst0;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;

    logic        pre_wr_en,  pre_wr_en0;
    logic [15:0] ov5640_data, ov5640_data0;
    logic        frame_start, frame_start0;
    logic        cap_err,    cap_err0;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_wr = 0;
    int          n_wr0 = 0;
    int          f_main = 0;
    bit          act = 1'b0;
    bit          act0 = 1'b0;
    bit          exp_err = 1'b0;
    bit          prev_wr = 1'b0;
    bit          prev_wr0 = 1'b0;
    logic [15:0] last_exp = '0;
    logic [15:0] last_exp0 = '0;

    exp_t        q_pix[$];
    exp_t        q_pix0[$];
    int          q_fs[$];
    int          q_fs0[$];

    ov5640_data_cap #(
        .FRAME_SKIP (MAIN_SKIP),
        .H_PIXELS   (4),
        .V_LINES    (2)
    ) u_dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .pre_wr_en   (pre_wr_en),
        .ov5640_data (ov5640_data),
        .frame_start (frame_start),
        .cap_err     (cap_err)
    );

    ov5640_data_cap #(
        .FRAME_SKIP (0),
        .H_PIXELS   (4),
        .V_LINES    (2)
    ) u_dut0 (
        .sys_clk     (sys_clk),
        .sys_rst     (rst0),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .pre_wr_en   (pre_wr_en0),
        .ov5640_data (ov5640_data0),
        .frame_start (frame_start0),
        .cap_err     (cap_err0)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor: pops expectations whenever a DUT presents a strobe, flags overdue entries.
    always @(negedge sys_clk) begin
        exp_t e;
        int   fs_due;
        if (cyc > 0) begin
            while (q_pix.size() > 0 && q_pix[0].due < cyc) begin
                e = q_pix.pop_front();
                n_checks++; n_errors++;
                $display("FAIL pix_missing: no strobe at cyc %0d, required data %h", e.due, e.data);
            end
            if (pre_wr_en) begin
                n_wr++;
                n_checks++;
                if (prev_wr) begin
                    n_errors++;
                    $display("FAIL wr_back_to_back: strobe at cyc %0d and cyc %0d", cyc - 1, cyc);
                end
                if (q_pix.size() == 0) begin
                    n_errors++;
                    $display("FAIL pix_unexpected: data %h at cyc %0d, required no strobe", ov5640_data, cyc);
                end else begin
                    e = q_pix.pop_front();
                    if (ov5640_data !== e.data || cyc != e.due) begin
                        n_errors++;
                        $display("FAIL pixel: got %h at cyc %0d, required %h at cyc %0d",
                                 ov5640_data, cyc, e.data, e.due);
                    end
                    last_exp = e.data;
                end
            end else begin
                n_checks++;
                if (ov5640_data !== last_exp) begin
                    n_errors++;
                    $display("FAIL data_hold: got %h at cyc %0d, required %h", ov5640_data, cyc, last_exp);
                end
            end
            prev_wr = pre_wr_en;

            while (q_fs.size() > 0 && q_fs[0] < cyc) begin
                fs_due = q_fs.pop_front();
                n_checks++; n_errors++;
                $display("FAIL fs_missing: no frame_start at cyc %0d", fs_due);
            end
            if (frame_start) begin
                n_checks++;
                if (q_fs.size() == 0 || q_fs[0] != cyc) begin
                    n_errors++;
                    $display("FAIL fs_unexpected: frame_start at cyc %0d, required none", cyc);
                end else begin
                    fs_due = q_fs.pop_front();
                end
            end

            while (q_pix0.size() > 0 && q_pix0[0].due < cyc) begin
                e = q_pix0.pop_front();
                n_checks++; n_errors++;
                $display("FAIL pix0_missing: no strobe at cyc %0d, required data %h", e.due, e.data);
            end
            if (pre_wr_en0) begin
                n_wr0++;
                n_checks++;
                if (prev_wr0) begin
                    n_errors++;
                    $display("FAIL wr0_back_to_back: strobe at cyc %0d and cyc %0d", cyc - 1, cyc);
                end
                if (q_pix0.size() == 0) begin
                    n_errors++;
                    $display("FAIL pix0_unexpected: data %h at cyc %0d, required no strobe", ov5640_data0, cyc);
                end else begin
                    e = q_pix0.pop_front();
                    if (ov5640_data0 !== e.data || cyc != e.due) begin
                        n_errors++;
                        $display("FAIL pixel0: got %h at cyc %0d, required %h at cyc %0d",
                                 ov5640_data0, cyc, e.data, e.due);
                    end
                    last_exp0 = e.data;
                end
            end else begin
                n_checks++;
                if (ov5640_data0 !== last_exp0) begin
                    n_errors++;
                    $display("FAIL data0_hold: got %h at cyc %0d, required %h", ov5640_data0, cyc, last_exp0);
                end
            end
            prev_wr0 = pre_wr_en0;

            while (q_fs0.size() > 0 && q_fs0[0] < cyc) begin
                fs_due = q_fs0.pop_front();
                n_checks++; n_errors++;
                $display("FAIL fs0_missing: no frame_start at cyc %0d", fs_due);
            end
            if (frame_start0) begin
                n_checks++;
                if (q_fs0.size() == 0 || q_fs0[0] != cyc) begin
                    n_errors++;
                    $display("FAIL fs0_unexpected: frame_start at cyc %0d, required none", cyc);
                end else begin
                    fs_due = q_fs0.pop_front();
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push_pix(input logic [15:0] d, input int due);
        exp_t e;
        e.data = d;
        e.due  = due;
        if (act)  q_pix.push_back(e);
        if (act0) q_pix0.push_back(e);
    endtask

    // Low byte driven now is sampled on the next edge; its strobe is due 3 edges from now.
    task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] seed, input bit keep_href);
        logic [7:0] hi;
        hi = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            cam_href = 1'b1;
            cam_data = (i == 0) ? b0 : (i == 1) ? b1 : seed + 8'(i * 13);
            if (i % 2 == 0) hi = cam_data;
            else            push_pix({hi, cam_data}, cyc + 3);
        end
        if (!keep_href) begin
            tick();
            cam_href = 1'b0;
            cam_data = '0;
            repeat (4) tick();
        end
    endtask

    task automatic frame_open();
        tick();
        cam_vsync = 1'b1;
        if (!sys_rst) begin
            f_main++;
            if (f_main > MAIN_SKIP) act = 1'b1;
        end
        if (!rst0) act0 = 1'b1;
        if (act)  q_fs.push_back(cyc + 2);
        if (act0) q_fs0.push_back(cyc + 2);
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic std_frame(input logic [7:0] seed);
        frame_open();
        send_bytes(8, seed, seed ^ 8'h5A, seed, 1'b0);
        send_bytes(8, seed + 8'h11, seed ^ 8'hC3, seed + 8'h22, 1'b0);
    endtask

    initial begin
        int base;
        sys_rst   = 1'b1;
        rst0      = 1'b1;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = '0;
        repeat (3) tick();
        check("rst_pre_wr_en", pre_wr_en, 0);
        check("rst_data", ov5640_data, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_cap_err", cap_err, 0);
        check("rst0_data", ov5640_data0, 0);
        sys_rst = 1'b0;
        repeat (3) tick();

        // Two skipped frames, then the first active frame.
        std_frame(8'h10);
        std_frame(8'h20);
        check("skip_no_strobes", n_wr, 0);
        std_frame(8'h30);
        check("frame3_strobes", n_wr, 8);

        // Byte order 0xF8,0x1F -> 0xF81F, then correct-geometry frames.
        frame_open();
        send_bytes(8, 8'hF8, 8'h1F, 8'h40, 1'b0);
        send_bytes(8, 8'h00, 8'hFF, 8'h55, 1'b0);
        std_frame(8'h60);
        std_frame(8'h70);
        check("frame4_6_strobes", n_wr, 32);

        // Odd line: 7 bytes give 3 pixels; next line restarts on a high byte.
        frame_open();
        check("geom_ok_cap_err", cap_err, exp_err);
        send_bytes(7, 8'hAA, 8'hBB, 8'h80, 1'b0);
`ifdef CAP_FRAME_CHECK_EN
        exp_err = 1'b1;
`endif
        check("odd_line_cap_err", cap_err, exp_err);
        send_bytes(8, 8'h12, 8'h34, 8'h90, 1'b0);
        check("odd_frame_strobes", n_wr, 39);
        frame_open();
        send_bytes(8, 8'hA1, 8'hB2, 8'hC3, 1'b0);
        check("cap_err_sticky", cap_err, exp_err);

        // Reset mid-line in ACTIVE.
        send_bytes(5, 8'hDE, 8'hAD, 8'hE0, 1'b1);
        tick();
        sys_rst  = 1'b1;
        cam_href = 1'b0;
        cam_data = '0;
        q_pix.delete();
        q_fs.delete();
        last_exp = '0;
        act      = 1'b0;
        f_main   = 0;
        exp_err  = 1'b0;
        #1;
        check("mid_rst_pre_wr_en", pre_wr_en, 0);
        check("mid_rst_data", ov5640_data, 0);
        check("mid_rst_frame_start", frame_start, 0);
        check("mid_rst_cap_err", cap_err, 0);
        repeat (3) tick();
        sys_rst = 1'b0;
        repeat (2) tick();
        base = n_wr;
        std_frame(8'h15);
        std_frame(8'h25);
        check("post_rst_skip", n_wr - base, 0);
        std_frame(8'h35);
        check("post_rst_strobes", n_wr - base, 8);

        // FRAME_SKIP=0 instance outputs from its first frame.
        rst0 = 1'b0;
        repeat (2) tick();
        std_frame(8'h45);
        check("skip0_strobes", n_wr0, 8);
        check("final_cap_err", cap_err, exp_err);
        check("skip0_cap_err", cap_err0, 0);

        repeat (10) tick();
        check("pix_queue_drained", q_pix.size(), 0);
        check("pix0_queue_drained", q_pix0.size(), 0);
        check("fs_queue_drained", q_fs.size() + q_fs0.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
